nios2_debug_cmd_sync: RTL and testbench



---
 rtl/nios2_debug_cmd_sync_if.sv | 33 +++
 rtl/nios2_debug_cmd_sync.sv | 133 +++++++++++++
 tb/tb_nios2_debug_cmd_sync.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/nios2_debug_cmd_sync_if.sv
// Command bus from the debug command bridge to the CPU debug logic:
// valid/ready handshake, head command data and per-IR-channel pulses.
interface nios2_debug_cmd_sync_if #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    localparam int NCH = 2**IR_WIDTH;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [SR_WIDTH-1:0] jdo;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [NCH-1:0]      take_action;
    logic [NCH-1:0]      take_no_action;

    modport master (
        output cmd_valid,
        output jdo,
        output cmd_ir,
        output take_action,
        output take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  jdo,
        input  cmd_ir,
        input  take_action,
        input  take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/nios2_debug_cmd_sync.sv
// System-clock side of the Nios II debug slave: synchronises the JTAG update
// toggle, queues captured {ir, sr} commands and issues action/no-action pulses.
module nios2_debug_cmd_sync #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACTION_BIT  = 35
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        udr_toggle,
    input  logic [SR_WIDTH-1:0]         sr_in,
    input  logic [IR_WIDTH-1:0]         ir_in,
    nios2_debug_cmd_sync_if.master      cmd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        overflow_clr
);
    localparam int NCH = 2**IR_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int EW  = IR_WIDTH + SR_WIDTH;
    localparam int CW  = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_DONE = CW'(SYNC_STAGES + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CW-1:0]          arm_cnt;
    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          count;
    logic [EW-1:0]          last_q;
    logic [NCH-1:0]         act_q;
    logic [NCH-1:0]         noact_q;

    logic           toggle_event;
    logic           armed;
    logic           push_req;
    logic           pop;
    logic           full;
    logic           push_ok;
    logic           drop;
    logic [EW-1:0]  head;
    logic [NCH-1:0] head_onehot;

    assign toggle_event = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign armed        = (arm_cnt == ARM_DONE);
    assign push_req     = toggle_event && armed;
    assign full         = (count == FULL_LVL);
    assign pop          = cmd.cmd_valid && cmd.cmd_ready;
    assign push_ok      = push_req && (!full || pop);
    assign drop         = push_req && full && !pop;
    assign head         = mem[rd_ptr];
    assign head_onehot  = NCH'(1) << head[EW-1:SR_WIDTH];

    // prev keeps following the synchroniser while disarmed, so a toggle level
    // already present when reset releases never looks like an update.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            arm_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], udr_toggle};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {ir_in, sr_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // last_q keeps the most recently accepted command visible once the queue drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= '0;
            act_q    <= '0;
            noact_q  <= '0;
            overflow <= 1'b0;
        end else begin
            act_q   <= '0;
            noact_q <= '0;
            if (pop) begin
                last_q <= head;
                if (head[ACTION_BIT]) begin
                    act_q <= head_onehot;
                end else begin
                    noact_q <= head_onehot;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign cmd.cmd_valid      = (count != '0);
    assign cmd.jdo            = cmd.cmd_valid ? head[SR_WIDTH-1:0] : last_q[SR_WIDTH-1:0];
    assign cmd.cmd_ir         = cmd.cmd_valid ? head[EW-1:SR_WIDTH] : last_q[EW-1:SR_WIDTH];
    assign cmd.take_action    = act_q;
    assign cmd.take_no_action = noact_q;
    assign fifo_level         = count;
endmodule

// File: tb/tb_nios2_debug_cmd_sync.sv
// Directed self-checking bench for nios2_debug_cmd_sync with default parameters
// (SR 38 bits, IR 2 bits, two sync stages, four-entry queue).
module tb_nios2_debug_cmd_sync;
    localparam int SRW = 38;
    localparam int IRW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           udr_toggle;
    logic [SRW-1:0] sr_in;
    logic [IRW-1:0] ir_in;
    logic [2:0]     fifo_level;
    logic           overflow;
    logic           overflow_clr;

    int total_checks = 0;
    int bad_checks   = 0;

    logic [SRW-1:0] data_q [5];

    nios2_debug_cmd_sync_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW)) cmd_bus ();

    nios2_debug_cmd_sync #(
        .SR_WIDTH(SRW), .IR_WIDTH(IRW), .SYNC_STAGES(2), .FIFO_DEPTH(4), .ACTION_BIT(35)
    ) dut (
        .clk(clk),
        .reset(reset),
        .udr_toggle(udr_toggle),
        .sr_in(sr_in),
        .ir_in(ir_in),
        .cmd(cmd_bus.master),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [IRW-1:0] ir, input logic [SRW-1:0] sr);
        ir_in      = ir;
        sr_in      = sr;
        udr_toggle = ~udr_toggle;
    endtask

    task automatic pushEntry(input logic [IRW-1:0] ir, input logic [SRW-1:0] sr);
        applyStimulus(ir, sr);
        repeat (4) stepClk();
    endtask

    // Accept the head, then check the pulse against the expected entry.
    task automatic popOne(input string tag, input logic [IRW-1:0] ir, input logic [SRW-1:0] sr);
        logic [3:0] onehot;
        onehot = 4'b0001 << ir;
        checkOutput({tag, "_valid"}, 64'(cmd_bus.cmd_valid), 64'd1);
        checkOutput({tag, "_jdo"}, 64'(cmd_bus.jdo), 64'(sr));
        checkOutput({tag, "_ir"}, 64'(cmd_bus.cmd_ir), 64'(ir));
        cmd_bus.cmd_ready = 1'b1;
        stepClk();
        cmd_bus.cmd_ready = 1'b0;
        checkOutput({tag, "_act"}, 64'(cmd_bus.take_action), sr[35] ? 64'(onehot) : 64'd0);
        checkOutput({tag, "_noact"}, 64'(cmd_bus.take_no_action), sr[35] ? 64'd0 : 64'(onehot));
    endtask

    initial begin
        reset             = 1'b1;
        udr_toggle        = 1'b1;
        sr_in             = '0;
        ir_in             = '0;
        overflow_clr      = 1'b0;
        cmd_bus.cmd_ready = 1'b0;
        repeat (3) stepClk();

        checkOutput("rst_valid", 64'(cmd_bus.cmd_valid), 64'd0);
        checkOutput("rst_jdo", 64'(cmd_bus.jdo), 64'd0);
        checkOutput("rst_ir", 64'(cmd_bus.cmd_ir), 64'd0);
        checkOutput("rst_act", 64'(cmd_bus.take_action), 64'd0);
        checkOutput("rst_noact", 64'(cmd_bus.take_no_action), 64'd0);
        checkOutput("rst_level", 64'(fifo_level), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);

        // Toggle already high at reset release must not create a command.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepClk();
            checkOutput("arm_valid", 64'(cmd_bus.cmd_valid), 64'd0);
        end
        checkOutput("arm_level", 64'(fifo_level), 64'd0);
        checkOutput("arm_ovf", 64'(overflow), 64'd0);

        // Single action update on IR 2 with the consumer always ready.
        cmd_bus.cmd_ready = 1'b1;
        applyStimulus(2'd2, 38'h08_1234_5678);
        stepClk();
        checkOutput("lat_e0", 64'(cmd_bus.cmd_valid), 64'd0);
        stepClk();
        checkOutput("lat_e1", 64'(cmd_bus.cmd_valid), 64'd0);
        stepClk();
        checkOutput("lat_e2", 64'(cmd_bus.cmd_valid), 64'd1);
        checkOutput("a_jdo", 64'(cmd_bus.jdo), 64'h08_1234_5678);
        checkOutput("a_ir", 64'(cmd_bus.cmd_ir), 64'd2);
        checkOutput("a_pre_act", 64'(cmd_bus.take_action), 64'd0);
        stepClk();
        checkOutput("a_act", 64'(cmd_bus.take_action), 64'h4);
        checkOutput("a_noact", 64'(cmd_bus.take_no_action), 64'd0);
        checkOutput("a_level", 64'(fifo_level), 64'd0);
        checkOutput("a_hold", 64'(cmd_bus.jdo), 64'h08_1234_5678);
        stepClk();
        checkOutput("a_act_end", 64'(cmd_bus.take_action), 64'd0);

        // No-action update on IR 0.
        applyStimulus(2'd0, 38'h07_0000_0001);
        repeat (4) stepClk();
        checkOutput("n_noact", 64'(cmd_bus.take_no_action), 64'h1);
        checkOutput("n_act", 64'(cmd_bus.take_action), 64'd0);
        stepClk();
        checkOutput("n_noact_end", 64'(cmd_bus.take_no_action), 64'd0);
        cmd_bus.cmd_ready = 1'b0;

        // Five updates with the consumer stalled: the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            data_q[i] = 38'h01_0000_0000 + 38'(i * 32'h1111);
            pushEntry(IRW'(i), data_q[i]);
            checkOutput("fill_level", 64'(fifo_level), (i < 4) ? 64'(i + 1) : 64'd4);
        end
        checkOutput("fill_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            popOne("drain", IRW'(i), data_q[i]);
        end
        checkOutput("drain_valid", 64'(cmd_bus.cmd_valid), 64'd0);
        checkOutput("drain_level", 64'(fifo_level), 64'd0);
        checkOutput("drain_hold", 64'(cmd_bus.jdo), 64'(data_q[3]));

        overflow_clr = 1'b1;
        stepClk();
        overflow_clr = 1'b0;
        checkOutput("ovf_clr", 64'(overflow), 64'd0);

        // Full queue, update lands in the same cycle as a pop.
        for (int i = 0; i < 5; i++) begin
            data_q[i] = 38'h08_0000_0000 + 38'(i * 32'h2222);
        end
        for (int i = 0; i < 4; i++) begin
            pushEntry(IRW'(i), data_q[i]);
        end
        applyStimulus(2'd3, data_q[4]);
        stepClk();
        stepClk();
        cmd_bus.cmd_ready = 1'b1;
        stepClk();
        cmd_bus.cmd_ready = 1'b0;
        checkOutput("pp_level", 64'(fifo_level), 64'd4);
        checkOutput("pp_ovf", 64'(overflow), 64'd0);
        checkOutput("pp_act", 64'(cmd_bus.take_action), 64'h1);
        for (int i = 1; i < 4; i++) begin
            popOne("pp_drain", IRW'(i), data_q[i]);
        end
        popOne("pp_last", 2'd3, data_q[4]);

        // Overflow clear in the same cycle as a drop loses to the set.
        for (int i = 0; i < 4; i++) begin
            pushEntry(IRW'(i), data_q[i]);
        end
        applyStimulus(2'd1, 38'h00_dead_beef);
        stepClk();
        stepClk();
        overflow_clr = 1'b1;
        stepClk();
        overflow_clr = 1'b0;
        checkOutput("clr_drop_ovf", 64'(overflow), 64'd1);
        checkOutput("clr_drop_level", 64'(fifo_level), 64'd4);

        // Start clean, queue three entries, then reset with the consumer ready.
        reset = 1'b1;
        stepClk();
        reset = 1'b0;
        repeat (6) stepClk();
        for (int i = 0; i < 3; i++) begin
            pushEntry(IRW'(i), data_q[i]);
        end
        checkOutput("pre_rst_level", 64'(fifo_level), 64'd3);
        reset             = 1'b1;
        cmd_bus.cmd_ready = 1'b1;
        stepClk();
        checkOutput("mid_rst_level", 64'(fifo_level), 64'd0);
        checkOutput("mid_rst_valid", 64'(cmd_bus.cmd_valid), 64'd0);
        checkOutput("mid_rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        stepClk();
        checkOutput("mid_rst_act", 64'(cmd_bus.take_action), 64'd0);
        checkOutput("mid_rst_noact", 64'(cmd_bus.take_no_action), 64'd0);
        checkOutput("mid_rst_jdo", 64'(cmd_bus.jdo), 64'd0);
        cmd_bus.cmd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
